// File: rtl/sar_adc_scan_ctrl.sv
// Multi-channel SAR ADC scan controller: drives a differential cap DAC, comparator and input mux.
// Optional oversampling (2^OSR_LOG2 averaged conversions per result) when SAR_ADC_OVERSAMPLE_EN is defined.
module sar_adc_scan_ctrl #(
    parameter int RESOLUTION    = 8,
    parameter int NUM_CH        = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int SAMPLE_W      = 4,
    parameter int OSR_LOG2      = 2,
    localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  continuous_i,
    input  logic [NUM_CH-1:0]     chan_mask_i,
    input  logic [SAMPLE_W-1:0]   sample_cycles_i,
    output logic [CH_W-1:0]       ch_sel_o,
    output logic                  sample_o,
    output logic [RESOLUTION-1:0] dac_p_o,
    output logic [RESOLUTION-1:0] dac_n_o,
    input  logic                  comp_p_i,
    input  logic                  comp_n_i,
    output logic                  busy_o,
    output logic                  result_valid_o,
    input  logic                  result_ready_i,
    output logic [RESOLUTION-1:0] result_o,
    output logic [CH_W-1:0]       result_ch_o,
    output logic                  result_err_o
);

    localparam int BIT_W = $clog2(RESOLUTION);
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [BIT_W-1:0] MSB_IDX     = BIT_W'(RESOLUTION - 1);

    if (RESOLUTION < 2 || NUM_CH < 1 || SETTLE_CYCLES < 1 || SAMPLE_W < 1 || OSR_LOG2 < 0) begin : g_paramCheck
        $error("sar_adc_scan_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONVERT,
        DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    logic [NUM_CH-1:0]     r_mask;
    logic                  r_continuous;
    logic [SAMPLE_W-1:0]   r_sampleLen;
    logic [SAMPLE_W-1:0]   r_sampleCnt;
    logic                  r_stopPending;
    logic [CH_W-1:0]       r_chSel;
    logic [BIT_W-1:0]      r_bitIdx;
    logic [SET_W-1:0]      r_settleCnt;
    logic [RESOLUTION-1:0] r_code;
    logic                  r_err;
    logic [RESOLUTION-1:0] r_result;
    logic [CH_W-1:0]       r_resultCh;
    logic                  r_resultErr;

    logic [RESOLUTION-1:0] w_trial;
    logic [RESOLUTION-1:0] w_codeNext;
    logic                  w_decide;
    logic                  w_keep;
    logic                  w_invalid;
    logic                  w_convEnd;
    logic                  w_sampleEnd;
    logic                  w_startOk;
    logic                  w_handshake;
    logic                  w_stop;
    logic                  w_lastSub;
    logic                  w_hasNext;
    logic [CH_W-1:0]       w_nextCh;
    logic [CH_W-1:0]       w_firstCh;
    logic [CH_W-1:0]       w_startCh;
    logic                  w_chLoad;
    logic [CH_W-1:0]       w_chNext;
    logic [RESOLUTION-1:0] w_resultNext;

    function automatic logic [CH_W-1:0] lowestSet(input logic [NUM_CH-1:0] m);
        lowestSet = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) lowestSet = CH_W'(i);
        end
    endfunction

    assign w_trial     = r_code | (RESOLUTION'(1) << r_bitIdx);
    assign w_decide    = (r_state == CONVERT) && (r_settleCnt == SETTLE_LAST);
    assign w_keep      = comp_p_i & ~comp_n_i;
    assign w_invalid   = (comp_p_i == comp_n_i);
    assign w_codeNext  = w_keep ? w_trial : r_code;
    assign w_convEnd   = w_decide && (r_bitIdx == '0);
    assign w_sampleEnd = (r_state == SAMPLE) && (r_sampleCnt == r_sampleLen);
    assign w_startOk   = start_i && (chan_mask_i != '0);
    assign w_handshake = (r_state == DONE) && result_ready_i;
    assign w_stop      = r_stopPending | stop_i;
    assign w_firstCh   = lowestSet(r_mask);
    assign w_startCh   = lowestSet(chan_mask_i);

    // Next enabled channel strictly above the current one, lowest first
    always_comb begin
        w_hasNext = 1'b0;
        w_nextCh  = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_mask[i] && (CH_W'(i) > r_chSel)) begin
                w_hasNext = 1'b1;
                w_nextCh  = CH_W'(i);
            end
        end
    end

`ifdef SAR_ADC_OVERSAMPLE_EN
    localparam int OSR_W = (OSR_LOG2 > 0) ? OSR_LOG2 : 1;
    localparam int ACC_W = RESOLUTION + OSR_LOG2;
    localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'((1 << OSR_LOG2) - 1);

    logic [OSR_W-1:0] r_osrCnt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_accNext;

    assign w_accNext    = r_acc + ACC_W'(w_codeNext);
    assign w_lastSub    = (r_osrCnt == OSR_LAST);
    assign w_resultNext = RESOLUTION'(w_accNext >> OSR_LOG2);

    // Sub-conversion accumulator, restarted whenever a new channel is selected
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_osrCnt <= '0;
            r_acc    <= '0;
        end else if (w_chLoad) begin
            r_osrCnt <= '0;
            r_acc    <= '0;
        end else if (w_convEnd) begin
            r_osrCnt <= r_osrCnt + 1'b1;
            r_acc    <= w_accNext;
        end
    end
`else
    assign w_lastSub    = 1'b1;
    assign w_resultNext = w_codeNext;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_nextState;
    end

    // Scan sequencing; w_chLoad marks entry to SAMPLE on a newly selected channel
    always_comb begin
        w_nextState = r_state;
        w_chLoad    = 1'b0;
        w_chNext    = r_chSel;
        case (r_state)
            IDLE: begin
                if (w_startOk) begin
                    w_nextState = SAMPLE;
                    w_chLoad    = 1'b1;
                    w_chNext    = w_startCh;
                end
            end
            SAMPLE: begin
                if (w_sampleEnd) w_nextState = CONVERT;
            end
            CONVERT: begin
                if (w_convEnd) w_nextState = w_lastSub ? DONE : SAMPLE;
            end
            DONE: begin
                if (w_handshake) begin
                    if (w_stop) begin
                        w_nextState = IDLE;
                    end else if (w_hasNext) begin
                        w_nextState = SAMPLE;
                        w_chLoad    = 1'b1;
                        w_chNext    = w_nextCh;
                    end else if (r_continuous) begin
                        w_nextState = SAMPLE;
                        w_chLoad    = 1'b1;
                        w_chNext    = w_firstCh;
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Configuration is captured once per scan so mid-scan input changes are ignored
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mask        <= '0;
            r_continuous  <= 1'b0;
            r_sampleLen   <= '0;
            r_stopPending <= 1'b0;
        end else begin
            if ((r_state == IDLE) && w_startOk) begin
                r_mask       <= chan_mask_i;
                r_continuous <= continuous_i;
                r_sampleLen  <= (sample_cycles_i == '0) ? SAMPLE_W'(1) : sample_cycles_i;
            end
            if (r_state == IDLE)  r_stopPending <= 1'b0;
            else if (stop_i)      r_stopPending <= 1'b1;
        end
    end

    // The first SAMPLE cycle lets the mux settle; the switch closes for the next r_sampleLen cycles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sampleCnt <= '0;
        end else if ((w_nextState == SAMPLE) && (r_state != SAMPLE)) begin
            r_sampleCnt <= '0;
        end else if (r_state == SAMPLE) begin
            r_sampleCnt <= r_sampleCnt + 1'b1;
        end
    end

    // Successive approximation: one bit per trial, MSB first, decided on the trial's last cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_chSel     <= '0;
            r_bitIdx    <= '0;
            r_settleCnt <= '0;
            r_code      <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_chLoad) begin
                r_chSel <= w_chNext;
                r_err   <= 1'b0;
            end
            if (w_sampleEnd) begin
                r_bitIdx    <= MSB_IDX;
                r_settleCnt <= '0;
                r_code      <= '0;
            end else if (r_state == CONVERT) begin
                if (w_decide) begin
                    r_settleCnt <= '0;
                    r_code      <= w_codeNext;
                    if (w_invalid)          r_err    <= 1'b1;
                    if (r_bitIdx != '0)     r_bitIdx <= r_bitIdx - 1'b1;
                end else begin
                    r_settleCnt <= r_settleCnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_result    <= '0;
            r_resultCh  <= '0;
            r_resultErr <= 1'b0;
        end else if (w_convEnd && w_lastSub) begin
            r_result    <= w_resultNext;
            r_resultCh  <= r_chSel;
            r_resultErr <= r_err | w_invalid;
        end
    end

    assign ch_sel_o       = r_chSel;
    assign sample_o       = (r_state == SAMPLE) && (r_sampleCnt != '0);
    assign dac_p_o        = (r_state == CONVERT) ? w_trial : '0;
    assign dac_n_o        = (r_state == CONVERT) ? ~w_trial : '0;
    assign busy_o         = (r_state != IDLE);
    assign result_valid_o = (r_state == DONE);
    assign result_o       = r_result;
    assign result_ch_o    = r_resultCh;
    assign result_err_o   = r_resultErr;

endmodule

// File: tb/tb_sar_adc_scan_ctrl.sv
// Scoreboard bench for sar_adc_scan_ctrl: an analog comparator model converts a chosen input level,
// expected channel/result pairs are queued at stimulus time and checked at each result handshake.
module tb_sar_adc_scan_ctrl;

    localparam int RES      = 8;
    localparam int NCH      = 4;
    localparam int SW       = 4;
    localparam int OSR_LOG2 = 2;
    localparam int CHW      = 2;
`ifdef SAR_ADC_OVERSAMPLE_EN
    localparam int SUBS  = 1 << OSR_LOG2;
    localparam int SHIFT = OSR_LOG2;
`else
    localparam int SUBS  = 1;
    localparam int SHIFT = 0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic           stop;
    logic           cont;
    logic [NCH-1:0] mask;
    logic [SW-1:0]  scyc;
    logic [CHW-1:0] chSel;
    logic           sample;
    logic [RES-1:0] dacP;
    logic [RES-1:0] dacN;
    logic           compP;
    logic           compN;
    logic           busy;
    logic           valid;
    logic           ready = 1'b0;
    logic [RES-1:0] result;
    logic [CHW-1:0] resCh;
    logic           resErr;

    sar_adc_scan_ctrl #(
        .RESOLUTION(RES), .NUM_CH(NCH), .SETTLE_CYCLES(1), .SAMPLE_W(SW), .OSR_LOG2(OSR_LOG2)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop), .continuous_i(cont),
        .chan_mask_i(mask), .sample_cycles_i(scyc), .ch_sel_o(chSel), .sample_o(sample),
        .dac_p_o(dacP), .dac_n_o(dacN), .comp_p_i(compP), .comp_n_i(compN), .busy_o(busy),
        .result_valid_o(valid), .result_ready_i(ready), .result_o(result),
        .result_ch_o(resCh), .result_err_o(resErr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [RES-1:0] res;
        logic           err;
    } exp_t;

    exp_t           resQ[$];
    logic [CHW-1:0] chQ[$];
    int             vinQ[$];
    int             errBitQ[$];
    int             dacLog[$];

    int   checks = 0;
    int   errors = 0;
    int   hsCount = 0;
    int   sampleRises = 0;
    int   readyMode = 0;
    bit   randErr = 1'b0;
    bit   logDac = 1'b0;
    int   curVin = 0;
    int   curErrBit = -1;
    logic curErrVal = 1'b0;
    int   compLowBit;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end
    endtask

    // Ideal SAR: keep each trial bit while the input is at or above the trial level
    function automatic logic [RES-1:0] sarModel(input int vin, input int errBit, output logic err);
        int code;
        code = 0;
        err  = 1'b0;
        for (int b = RES - 1; b >= 0; b--) begin
            if (b == errBit) err = 1'b1;
            else if (vin >= (code | (1 << b))) code = code | (1 << b);
        end
        return RES'(code);
    endfunction

    // Comparator model; the trial bit is the lowest set bit of the DAC code
    always_comb begin
        compLowBit = -1;
        for (int b = RES - 1; b >= 0; b--) if (dacP[b]) compLowBit = b;
        compP = 1'b0;
        compN = 1'b0;
        if (dacP != '0) begin
            if (compLowBit == curErrBit) begin
                compP = curErrVal;
                compN = curErrVal;
            end else begin
                compP = (32'(dacP) <= curVin);
                compN = !(32'(dacP) <= curVin);
            end
        end
    end

    // Analog stimulus: a new input level per conversion, expected result queued immediately
    initial begin : analogStim
        bit   prevSample;
        int   subCnt;
        int   accSum;
        logic accErr;
        logic e;
        logic [RES-1:0] code;
        prevSample = 1'b0; subCnt = 0; accSum = 0; accErr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prevSample = 1'b0; subCnt = 0; accSum = 0; accErr = 1'b0;
            end else begin
                if (sample && !prevSample) begin
                    sampleRises++;
                    if (vinQ.size() > 0) begin
                        curVin    = vinQ.pop_front();
                        curErrBit = errBitQ.pop_front();
                    end else begin
                        curVin    = int'($urandom_range(0, 255));
                        curErrBit = (randErr && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, RES - 1)) : -1;
                    end
                    curErrVal = 1'($urandom_range(0, 1));
                    code   = sarModel(curVin, curErrBit, e);
                    accSum = accSum + int'(code);
                    accErr = accErr | e;
                    subCnt++;
                    if (subCnt == SUBS) begin
                        resQ.push_back('{res: RES'(accSum >> SHIFT), err: accErr});
                        subCnt = 0; accSum = 0; accErr = 1'b0;
                    end
                end
                prevSample = sample;
            end
        end
    end

    // Output monitor: ready policy, stall stability, DAC complement, and scoreboard pops
    initial begin : monitor
        bit   holding;
        logic [RES+CHW:0] held;
        logic [RES-1:0] expN;
        exp_t x;
        logic [CHW-1:0] c;
        holding = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            case (readyMode)
                0:       ready = 1'b1;
                1:       ready = ($urandom_range(0, 2) != 0);
                default: ready = 1'b0;
            endcase
            if (!rst_n) begin
                holding = 1'b0;
            end else begin
                expN = (dacP != '0) ? ~dacP : '0;
                checkOutput("dac_n_complement", dacN, expN);
                if (logDac && dacP != '0) dacLog.push_back(int'(dacP));
                if (valid) begin
                    if (holding) checkOutput("stall_stable", {resCh, resErr, result}, held);
                    if (ready) begin
                        if (chQ.size() == 0 || resQ.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_result: got ch %0d result 'h%0h, expected no result", resCh, result);
                        end else begin
                            c = chQ.pop_front();
                            x = resQ.pop_front();
                            checkOutput("result_ch", resCh, c);
                            checkOutput("result", result, x.res);
                            checkOutput("result_err", resErr, x.err);
                        end
                        hsCount++;
                        holding = 1'b0;
                    end else begin
                        holding = 1'b1;
                        held = {resCh, resErr, result};
                    end
                end else begin
                    holding = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pushDirected(input int vin, input int errBit);
        for (int i = 0; i < SUBS; i++) begin
            vinQ.push_back(vin);
            errBitQ.push_back(errBit);
        end
    endtask

    // Start a scan and queue the channel order the scan rules imply
    task automatic applyStimulus(input logic [NCH-1:0] m, input logic c, input logic [SW-1:0] s, input int nRes);
        int chans[$];
        for (int i = 0; i < NCH; i++) if (m[i]) chans.push_back(i);
        for (int i = 0; i < nRes; i++) chQ.push_back(CHW'(chans[i % chans.size()]));
        mask  = m;
        cont  = c;
        scyc  = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        mask  = NCH'($urandom);
        cont  = 1'($urandom);
        scyc  = SW'($urandom);
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_reached", busy, 1'b0);
    endtask

    task automatic waitHs(input int target, input int budget);
        int n;
        n = 0;
        while (hsCount < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput("handshake_reached", (hsCount >= target), 1'b1);
    endtask

    task automatic waitConvert(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (dacP == '0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("convert_reached", (dacP != '0), 1'b1);
    endtask

    task automatic checkDrained();
        checkOutput("queues_drained", chQ.size() + resQ.size(), 0);
    endtask

    initial begin : stimulus
        int lat;
        int base;
        int n;
        int expSeq[8];
        logic [NCH-1:0] m;
        expSeq = '{'h80, 'hC0, 'hA0, 'hB0, 'hA8, 'hAC, 'hAE, 'hAD};
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0; mask = '0; scyc = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {chSel, sample, dacP, dacN, busy, valid, result, resCh, resErr}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // start with an empty mask is ignored
        mask = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        checkOutput("mask0_ignored", busy, 1'b0);

        // single channel, pattern AD, latency and DAC trial sequence
        pushDirected('hAD, -1);
        logDac = 1'b1;
        dacLog.delete();
        applyStimulus(4'b0001, 1'b0, 4'd2, 1);
        lat = -1;
        for (int e = 1; e <= 200; e++) begin
            if (valid) break;
            @(posedge clk);
            #1;
            if (valid) lat = e;
        end
`ifndef SAR_ADC_OVERSAMPLE_EN
        checkOutput("latency_edges", lat, 11);
`endif
        waitIdle(500);
        logDac = 1'b0;
        checkOutput("dac_log_len", (dacLog.size() >= 8), 1'b1);
        for (int i = 0; i < 8 && i < dacLog.size(); i++) checkOutput("dac_trial_seq", dacLog[i], expSeq[i]);
        checkDrained();

        // single mode over two channels, full scale then zero
        pushDirected('hFF, -1);
        pushDirected('h00, -1);
        applyStimulus(4'b1010, 1'b0, 4'd3, 2);
        waitIdle(1000);
        checkOutput("single_end_valid", valid, 1'b0);
        checkDrained();

        // continuous scan stopped during the second conversion; busy starts ignored
        base = hsCount;
        applyStimulus(4'b0110, 1'b1, 4'd1, 2);
        waitHs(base + 1, 1000);
        waitConvert(200);
        stop = 1'b1; mask = 4'b1111; start = 1'b1;
        @(negedge clk);
        stop = 1'b0; start = 1'b0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitIdle(1000);
        checkOutput("stop_result_count", hsCount - base, 2);
        checkDrained();

        // consumer stall for 20 cycles in DONE
        @(posedge clk);
        readyMode = 2;
        @(negedge clk);
        base = hsCount;
        applyStimulus(4'b0011, 1'b0, 4'd2, 2);
        n = 0;
        while (!valid && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (20) begin
            @(negedge clk);
            checkOutput("stall_valid", valid, 1'b1);
            checkOutput("stall_no_sample", sample, 1'b0);
        end
        @(posedge clk);
        readyMode = 0;
        waitHs(base + 1, 50);
        @(negedge clk);
        checkOutput("after_hs_valid", valid, 1'b0);
        @(negedge clk);
        checkOutput("resume_sample", sample, 1'b1);
        waitIdle(1000);
        checkDrained();

        // invalid comparator decision on bit 5
        pushDirected('hFF, 5);
        applyStimulus(4'b0001, 1'b0, 4'd2, 1);
        waitIdle(500);
        checkDrained();

        // asynchronous reset in the middle of a conversion
        applyStimulus(4'b0100, 1'b0, 4'd1, 1);
        waitConvert(200);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_outputs", {chSel, sample, dacP, dacN, busy, valid, result, resCh, resErr}, 32'h0);
        chQ.delete();
        resQ.delete();
        @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_idle", busy, 1'b0);

`ifdef SAR_ADC_OVERSAMPLE_EN
        // four sub-conversions averaged by truncation
        vinQ.push_back('hFF); errBitQ.push_back(-1);
        vinQ.push_back('hFF); errBitQ.push_back(-1);
        vinQ.push_back('hFE); errBitQ.push_back(-1);
        vinQ.push_back('hFE); errBitQ.push_back(-1);
        base = sampleRises;
        applyStimulus(4'b0001, 1'b0, 4'd1, 1);
        waitIdle(1000);
        checkOutput("osr_sample_pulses", sampleRises - base, 4);
        checkDrained();
`endif

        // randomized scans with random ready and occasional comparator errors
        randErr = 1'b1;
        @(posedge clk);
        readyMode = 1;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            m = NCH'($urandom_range(1, (1 << NCH) - 1));
            if ($urandom_range(0, 1) == 1) begin
                n = int'($urandom_range(2, 5));
                base = hsCount;
                applyStimulus(m, 1'b1, SW'($urandom_range(0, 15)), n);
                waitHs(base + n - 1, 5000);
                @(negedge clk);
                stop = 1'b1;
                @(negedge clk);
                stop = 1'b0;
                waitIdle(5000);
                checkOutput("cont_result_count", hsCount - base, n);
            end else begin
                applyStimulus(m, 1'b0, SW'($urandom_range(0, 15)), $countones(m));
                waitIdle(5000);
            end
            checkDrained();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
